// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Performs request-to-send, shifts a byte out on device clocks, captures the ACK and times out.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAck,
    output logic       oError,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPs2ClkOe,
    output logic       oPs2DataOe
);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INH_DATA = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          fall, lines_idle, timeout;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], iPs2Clk};
        data_sync_d = {data_sync_q[0], iPs2Data};
        // stage [2] is the previous synchronized sample, used only for edge detection
        fall        = clk_sync_q[2] & ~clk_sync_q[1];
        lines_idle  = clk_sync_q[1] & data_sync_q[1];
        timeout     = timer_q == TO_LIM;
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ack_d       = ack_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (iSend) begin
                    state_d   = INHIBIT;
                    shift_d   = {~^iData, iData};
                    ack_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = INHIBIT_CYCLES == 1;
                end
            end
            INHIBIT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == INH_DATA) data_oe_d = 1'b1;
                if (timer_q == INH_LAST) state_d = REQ;
            end
            REQ: begin
                state_d  = SHIFT;
                clk_oe_d = 1'b0;
                timer_d  = '0;
                cnt_d    = '0;
            end
            SHIFT, ACK, WAIT_IDLE: begin
                timer_d = timer_q + TW'(1);
                // timeout is checked first so it beats a coincident ACK edge or idle detection
                if (timeout) begin
                    state_d   = IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_d     = 1'b0;
                    err_d     = 1'b1;
                    timer_d   = '0;
                end else if (state_q == SHIFT) begin
                    if (fall) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd9) begin
                            data_oe_d = 1'b0;
                            state_d   = ACK;
                        end else begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b0, shift_q[8:1]};
                        end
                    end
                end else if (state_q == ACK) begin
                    if (fall) begin
                        ack_d   = ~data_sync_q[1];
                        state_d = WAIT_IDLE;
                    end
                end else if (lines_idle) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oAck       = ack_q;
    assign oError     = err_q;
    assign oPs2ClkOe  = clk_oe_q;
    assign oPs2DataOe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model driving ps2_host_tx, checked against frame rules.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_data;
    logic       send;
    logic       busy, done, ack, err, clk_oe, data_oe;
    logic       dev_clk, dev_data;
    logic       ps2_clk, ps2_data;
    int         total = 0;
    int         bad = 0;

    assign ps2_clk  = dev_clk & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
        .Clock(clk), .Reset(rst_n), .iData(i_data), .iSend(send),
        .oBusy(busy), .oDone(done), .oAck(ack), .oError(err),
        .iPs2Clk(ps2_clk), .iPs2Data(ps2_data),
        .oPs2ClkOe(clk_oe), .oPs2DataOe(data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // start, 8 data bits LSB first, odd parity, stop; start bit checked separately
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2) == 0, b};
    endfunction

    task automatic start_frame(input logic [7:0] b);
        i_data = b;
        send = 1'b1;
        @(negedge clk);
        check("busy_on", busy, 1);
        send = 1'b0;
        i_data = 8'($urandom);
    endtask

    task automatic measure_inhibit();
        int n = 0;
        int rise = 0;
        while (clk_oe && n < 100) begin
            n++;
            if (data_oe && rise == 0) rise = n;
            @(negedge clk);
        end
        check("inh_len", n, 21);
        check("data_rise", rise, 20);
    endtask

    task automatic run_device(input logic [7:0] b, input bit want_ack, input bit hold,
                              input logic [7:0] b2, input int abort_edge);
        logic [9:0] got;
        bit seen;
        check("start_bit", ps2_data, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            if (i == 2) begin
                send = 1'b1;
                i_data = 8'($urandom);
            end
            repeat (6) @(negedge clk);
            send = 1'b0;
            got[i] = ps2_data;
            if (i + 1 == abort_edge) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_clk_oe", clk_oe, 0);
                check("rst_data_oe", data_oe, 0);
                check("rst_busy", busy, 0);
                dev_clk = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                return;
            end
            dev_clk = 1'b1;
            repeat (6) @(negedge clk);
        end
        check("frame", got, frame_of(b));
        if (hold) begin
            send = 1'b1;
            i_data = b2;
        end
        if (want_ack) dev_data = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (6) @(negedge clk);
        dev_clk = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (n == 2) dev_data = 1'b1;
            if (done) begin
                seen = 1'b1;
                check("ack", ack, want_ack);
                check("err_clear", err, 0);
            end
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        if (hold) begin
            check("b2b_busy", busy, 1);
            check("b2b_clk_oe", clk_oe, 1);
            send = 1'b0;
        end else begin
            check("busy_off", busy, 0);
            check("done_pulse", done, 0);
            check("ack_hold", ack, want_ack);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit a;
        int n;
        bit done_seen;
        rst_n = 1'b0;
        send = 1'b0;
        i_data = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_ack0", ack, 0);
        check("rst_err0", err, 0);
        check("rst_clkoe0", clk_oe, 0);
        check("rst_dataoe0", data_oe, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // directed bytes from the command set and parity corners
        start_frame(8'hED); measure_inhibit(); run_device(8'hED, 1, 0, 8'h00, 0);
        start_frame(8'h00); measure_inhibit(); run_device(8'h00, 1, 0, 8'h00, 0);
        start_frame(8'h01); measure_inhibit(); run_device(8'h01, 1, 0, 8'h00, 0);
        start_frame(8'hA5); measure_inhibit(); run_device(8'hA5, 0, 0, 8'h00, 0);
        // timeout: device never clocks
        start_frame(8'h3C);
        measure_inhibit();
        n = 0;
        done_seen = 1'b0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
            if (done) done_seen = 1'b1;
        end
        check("to_cycles", n, 201);
        check("to_clk_oe", clk_oe, 0);
        check("to_data_oe", data_oe, 0);
        check("to_busy", busy, 0);
        check("to_ack", ack, 0);
        check("to_no_done", done_seen, 0);
        @(negedge clk);
        check("to_pulse", err, 0);
        // back-to-back with send held across the return to idle
        start_frame(8'h5A); measure_inhibit(); run_device(8'h5A, 1, 1, 8'hC3, 0);
        measure_inhibit(); run_device(8'hC3, 1, 0, 8'h00, 0);
        // async reset during the last inhibit cycle, both lines driven
        start_frame(8'h12);
        repeat (19) @(negedge clk);
        check("pre_rst_clk", clk_oe, 1);
        check("pre_rst_data", data_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("inh_rst_clk", clk_oe, 0);
        check("inh_rst_data", data_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // reset after edge 5 of 0xF4, then a clean 0xFF
        start_frame(8'hF4); measure_inhibit(); run_device(8'hF4, 1, 0, 8'h00, 5);
        repeat (3) @(negedge clk);
        start_frame(8'hFF); measure_inhibit(); run_device(8'hFF, 1, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            a = 1'($urandom_range(0, 1));
            start_frame(b);
            measure_inhibit();
            run_device(b, a, 0, 8'h00, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
